// File: rtl/fpu_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpu_adder_pipe                                               |
// | Description : Three-stage pipelined IEEE-754 add/subtract with             |
// |               valid/ready handshakes, round-to-nearest-even, flush-to-zero |
// |               and special-value handling.                                  |
// |               Optional build macro FPU_ADDER_FLAGS_EN adds o_flags         |
// |               {invalid, overflow, underflow, inexact}.                     |
// | Revision    : 1.0 - initial pipelined release                              |
// +----------------------------------------------------------------------------+
module fpu_adder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [EXP_W+MAN_W:0] i_b,
  input  logic                 i_sub,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [EXP_W+MAN_W:0] o_result
`ifdef FPU_ADDER_FLAGS_EN
  ,
  output logic [3:0]           o_flags
`endif
);

  localparam int c_W   = 1 + EXP_W + MAN_W;
  localparam int c_AW  = MAN_W + 4;             // hidden, mantissa, guard, round, sticky
  localparam int c_SW  = MAN_W + 5;             // aligned width plus carry
  localparam int c_VW  = MAN_W + 3;             // aligned width without sticky
  localparam int c_EW  = EXP_W + 2;             // two's-complement exponent with headroom
  localparam int c_LZW = $clog2(c_AW) + 1;
  localparam logic [EXP_W-1:0] c_EMAX   = '1;
  localparam logic [EXP_W-1:0] c_VW_E   = EXP_W'(c_VW);
  localparam logic [c_W-1:0]   c_QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------------------------------------------------------- handshake
  logic r_s3_valid;
  logic w_adv;

  // The whole pipe freezes while the head result waits on the consumer.
  assign w_adv   = ~(r_s3_valid & ~i_ready);
  assign o_ready = w_adv;
  assign o_valid = r_s3_valid;

  // ---------------------------------------------------------------- stage 1
  logic                   w_sa, w_sb, w_sl;
  logic [EXP_W-1:0]       w_ea, w_eb, w_el, w_es, w_diff;
  logic [MAN_W-1:0]       w_ma, w_mb;
  logic                   w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic [MAN_W:0]         w_hm_a, w_hm_b, w_ml, w_ms;
  logic [c_W-2:0]         w_mag_a, w_mag_b;
  logic                   w_swap;
  logic [2*c_VW-1:0]      w_ext, w_shf;
  logic [c_AW-1:0]        w_al_s;
  logic                   w_spec;
  logic [c_W-1:0]         w_spec_res;
  logic                   w_spec_inv;

  assign w_sa     = i_a[c_W-1];
  assign w_sb     = i_b[c_W-1] ^ i_sub;
  assign w_ea     = i_a[c_W-2 -: EXP_W];
  assign w_eb     = i_b[c_W-2 -: EXP_W];
  assign w_ma     = i_a[MAN_W-1:0];
  assign w_mb     = i_b[MAN_W-1:0];
  assign w_nan_a  = (w_ea == c_EMAX) && (w_ma != '0);
  assign w_nan_b  = (w_eb == c_EMAX) && (w_mb != '0);
  assign w_inf_a  = (w_ea == c_EMAX) && (w_ma == '0);
  assign w_inf_b  = (w_eb == c_EMAX) && (w_mb == '0);
  assign w_zero_a = (w_ea == '0);
  assign w_zero_b = (w_eb == '0);
  // Subnormals are flushed: a zero exponent contributes no significand at all.
  assign w_hm_a   = w_zero_a ? '0 : {1'b1, w_ma};
  assign w_hm_b   = w_zero_b ? '0 : {1'b1, w_mb};
  assign w_mag_a  = w_zero_a ? '0 : i_a[c_W-2:0];
  assign w_mag_b  = w_zero_b ? '0 : i_b[c_W-2:0];
  assign w_swap   = (w_mag_b > w_mag_a);
  assign w_sl     = w_swap ? w_sb : w_sa;
  assign w_el     = w_swap ? w_eb : w_ea;
  assign w_es     = w_swap ? w_ea : w_eb;
  assign w_ml     = w_swap ? w_hm_b : w_hm_a;
  assign w_ms     = w_swap ? w_hm_a : w_hm_b;
  assign w_diff   = w_el - w_es;
  assign w_ext    = {w_ms, 2'b00, {c_VW{1'b0}}};
  assign w_shf    = w_ext >> w_diff;

  // Align the smaller significand; everything shifted past round collapses into sticky.
  always_comb begin
    if (w_diff >= c_VW_E) begin
      w_al_s = {{c_VW{1'b0}}, |w_ms};
    end else begin
      w_al_s = {w_shf[2*c_VW-1:c_VW], |w_shf[c_VW-1:0]};
    end
  end

  // Resolve NaN, infinity and zero+zero cases up front; they skip the datapath.
  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_inv = 1'b0;
    if (w_nan_a || w_nan_b) begin
      w_spec_res = c_QNAN;
    end else if (w_inf_a && w_inf_b && (w_sa != w_sb)) begin
      w_spec_res = c_QNAN;
      w_spec_inv = 1'b1;
    end else if (w_inf_a) begin
      w_spec_res = {w_sa, c_EMAX, {MAN_W{1'b0}}};
    end else if (w_inf_b) begin
      w_spec_res = {w_sb, c_EMAX, {MAN_W{1'b0}}};
    end else if (w_zero_a && w_zero_b) begin
      w_spec_res = {w_sa & w_sb, {(c_W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  logic                   r_s1_valid, r_s1_sign, r_s1_sub, r_s1_spec;
  logic [EXP_W-1:0]       r_s1_exp;
  logic [c_AW-1:0]        r_s1_ml, r_s1_ms;
  logic [c_W-1:0]         r_s1_spec_res;
`ifdef FPU_ADDER_FLAGS_EN
  logic                   r_s1_inv;
`endif

  // Stage 1 register: aligned operands plus any bypass result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_sign     <= 1'b0;
      r_s1_sub      <= 1'b0;
      r_s1_spec     <= 1'b0;
      r_s1_exp      <= '0;
      r_s1_ml       <= '0;
      r_s1_ms       <= '0;
      r_s1_spec_res <= '0;
`ifdef FPU_ADDER_FLAGS_EN
      r_s1_inv      <= 1'b0;
`endif
    end else if (w_adv) begin
      r_s1_valid    <= i_valid;
      r_s1_sign     <= w_sl;
      r_s1_sub      <= w_sa ^ w_sb;
      r_s1_spec     <= w_spec;
      r_s1_exp      <= w_el;
      r_s1_ml       <= {w_ml, 3'b000};
      r_s1_ms       <= w_al_s;
      r_s1_spec_res <= w_spec_res;
`ifdef FPU_ADDER_FLAGS_EN
      r_s1_inv      <= w_spec_inv;
`endif
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [c_SW-1:0]  w_sum;

  // Larger magnitude is always the minuend, so the difference is never negative.
  assign w_sum = r_s1_sub ? ({1'b0, r_s1_ml} - {1'b0, r_s1_ms})
                          : ({1'b0, r_s1_ml} + {1'b0, r_s1_ms});

  logic                   r_s2_valid, r_s2_sign, r_s2_spec;
  logic [EXP_W-1:0]       r_s2_exp;
  logic [c_SW-1:0]        r_s2_sum;
  logic [c_W-1:0]         r_s2_spec_res;
`ifdef FPU_ADDER_FLAGS_EN
  logic                   r_s2_inv;
`endif

  // Stage 2 register: raw significand sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid    <= 1'b0;
      r_s2_sign     <= 1'b0;
      r_s2_spec     <= 1'b0;
      r_s2_exp      <= '0;
      r_s2_sum      <= '0;
      r_s2_spec_res <= '0;
`ifdef FPU_ADDER_FLAGS_EN
      r_s2_inv      <= 1'b0;
`endif
    end else if (w_adv) begin
      r_s2_valid    <= r_s1_valid;
      r_s2_sign     <= r_s1_sign;
      r_s2_spec     <= r_s1_spec;
      r_s2_exp      <= r_s1_exp;
      r_s2_sum      <= w_sum;
      r_s2_spec_res <= r_s1_spec_res;
`ifdef FPU_ADDER_FLAGS_EN
      r_s2_inv      <= r_s1_inv;
`endif
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [c_LZW-1:0]  w_lzc;
  logic [c_AW-1:0]   w_norm;
  logic [c_EW-1:0]   w_exp_n, w_exp_r;
  logic              w_rup;
  logic [MAN_W+1:0]  w_mant;
  logic [MAN_W-1:0]  w_mant_f;
  logic              w_ovf, w_unf;
  logic [c_W-1:0]    w_res;

  // Leading-zero count of the non-carry sum; the highest set bit wins.
  always_comb begin
    w_lzc = '0;
    for (int k = 0; k < c_AW; k++) begin
      if (r_s2_sum[k]) w_lzc = c_LZW'(c_AW - 1 - k);
    end
  end

  // Normalise: a carry shifts right once, otherwise shift left by the zero count.
  always_comb begin
    if (r_s2_sum[c_SW-1]) begin
      w_norm  = {r_s2_sum[c_SW-1:2], r_s2_sum[1] | r_s2_sum[0]};
      w_exp_n = {2'b00, r_s2_exp} + c_EW'(1);
    end else begin
      w_norm  = r_s2_sum[c_AW-1:0] << w_lzc;
      w_exp_n = {2'b00, r_s2_exp} - {{(c_EW-c_LZW){1'b0}}, w_lzc};
    end
  end

  assign w_rup  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mant = {1'b0, w_norm[c_AW-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};

  // A rounding carry-out turns 1.111.. into 10.000.., so bump the exponent.
  always_comb begin
    if (w_mant[MAN_W+1]) begin
      w_exp_r  = w_exp_n + c_EW'(1);
      w_mant_f = w_mant[MAN_W:1];
    end else begin
      w_exp_r  = w_exp_n;
      w_mant_f = w_mant[MAN_W-1:0];
    end
  end

  assign w_ovf = ~w_exp_r[c_EW-1] && (w_exp_r >= {2'b00, c_EMAX});
  assign w_unf = w_exp_r[c_EW-1] || (w_exp_r == '0);

  // Pick the packed result: bypass, exact cancellation, overflow, underflow or normal.
  always_comb begin
    if (r_s2_spec) begin
      w_res = r_s2_spec_res;
    end else if (r_s2_sum == '0) begin
      w_res = '0;
    end else if (w_ovf) begin
      w_res = {r_s2_sign, c_EMAX, {MAN_W{1'b0}}};
    end else if (w_unf) begin
      w_res = {r_s2_sign, {(c_W-1){1'b0}}};
    end else begin
      w_res = {r_s2_sign, w_exp_r[EXP_W-1:0], w_mant_f};
    end
  end

  logic [c_W-1:0] r_s3_res;

  // Stage 3 register: the visible result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_res   <= '0;
    end else if (w_adv) begin
      r_s3_valid <= r_s2_valid;
      r_s3_res   <= w_res;
    end
  end

  assign o_result = r_s3_res;

`ifdef FPU_ADDER_FLAGS_EN
  logic [3:0] w_flags;
  logic [3:0] r_s3_flags;

  // Flags follow the same priority as the result selection.
  always_comb begin
    if (r_s2_spec) begin
      w_flags = {r_s2_inv, 3'b000};
    end else if (r_s2_sum == '0) begin
      w_flags = 4'b0000;
    end else if (w_ovf) begin
      w_flags = 4'b0101;
    end else if (w_unf) begin
      w_flags = 4'b0011;
    end else begin
      w_flags = {3'b000, w_norm[2] | w_norm[1] | w_norm[0]};
    end
  end

  // Flags are registered alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_flags <= '0;
    end else if (w_adv) begin
      r_s3_flags <= w_flags;
    end
  end

  assign o_flags = r_s3_flags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fpu_adder_pipe                                            |
// | Description : Self-checking bench for fpu_adder_pipe: directed vectors,    |
// |               back-pressure, mid-flight reset and random traffic against   |
// |               a real-arithmetic reference. Honours FPU_ADDER_FLAGS_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fpu_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_sub = 1'b0;
  logic        i_ready = 1'b1;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_result;
`ifdef FPU_ADDER_FLAGS_EN
  logic [3:0]  o_flags;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, in_cyc = 0, out_cyc = 0, out_cnt = 0;
  logic [31:0] last_res = '0;
  logic [3:0]  last_flags = '0;
  logic        snap_ready = 1'b0, snap_valid = 1'b0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_sub    (i_sub),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
`ifdef FPU_ADDER_FLAGS_EN
    ,
    .o_flags  (o_flags)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic real to_real(input logic s, input logic [7:0] e, input logic [22:0] m);
    logic [10:0] de;
    de = 11'(e) + 11'd896;
    return $bitstoreal({s, de, m, 29'b0});
  endfunction

  // Reference: exact-enough double arithmetic, then RNE to single by hand.
  // Returns {flags[3:0], result[31:0]}.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b_in, input logic sub);
    logic [31:0] b;
    logic        sa, sb, sr, up, inx;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    real         ra, rb, s, bv, err;
    logic [63:0] db;
    int          fe;
    logic [23:0] keep;
    logic [28:0] rem;
    logic [24:0] mant;
    b = b_in;
    b[31] = b_in[31] ^ sub;
    sa = a[31]; ea = a[30:23]; ma = a[22:0];
    sb = b[31]; eb = b[30:23]; mb = b[22:0];
    if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0)) return {4'h0, 32'h7FC00000};
    if (ea == 8'hFF && eb == 8'hFF && sa != sb) return {4'h8, 32'h7FC00000};
    if (ea == 8'hFF) return {4'h0, sa, 8'hFF, 23'h0};
    if (eb == 8'hFF) return {4'h0, sb, 8'hFF, 23'h0};
    if (ea == 0 && eb == 0) return {4'h0, sa & sb, 31'h0};
    ra = (ea == 0) ? 0.0 : to_real(sa, ea, ma);
    rb = (eb == 0) ? 0.0 : to_real(sb, eb, mb);
    s = ra + rb;
    if (s == 0.0) return {4'h0, 32'h0};
    bv  = s - ra;
    err = (ra - (s - bv)) + (rb - bv);
    db  = $realtobits(s);
    sr  = db[63];
    fe  = int'(db[62:52]) - 896;
    keep = {1'b1, db[51:29]};
    rem  = db[28:0];
    up   = rem[28] && ((rem[27:0] != 0) || keep[0]);
    inx  = (rem != 0) || (err != 0.0);
    mant = {1'b0, keep} + 25'(up);
    if (mant[24]) begin
      mant = mant >> 1;
      fe = fe + 1;
    end
    if (fe >= 255) return {4'b0101, sr, 8'hFF, 23'h0};
    if (fe <= 0) return {4'b0011, sr, 31'h0};
    return {3'b000, inx, sr, 8'(fe), mant[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = '0; end
      1: v[30:23] = 8'h00;
      2, 3: v[30:23] = 8'd120 + 8'($urandom_range(0, 15));
      4: v[30:23] = 8'hFE;
      5: v[30:23] = 8'd1 + 8'($urandom_range(0, 3));
      default: ;
    endcase
    return v;
  endfunction

  // One clock: sample handshakes 1 unit before the rising edge, return at the next falling edge.
  task automatic cycle();
    logic [35:0] e;
    #4;
    snap_ready = o_ready;
    snap_valid = o_valid;
    if (i_valid && o_ready) begin
      exp_q.push_back(ref_add(i_a, i_b, i_sub));
      in_cyc = cyc;
    end
    if (o_valid && i_ready) begin
      out_cyc = cyc;
      out_cnt++;
      last_res = o_result;
`ifdef FPU_ADDER_FLAGS_EN
      last_flags = o_flags;
`endif
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", 64'(o_result), 64'(e[31:0]));
`ifdef FPU_ADDER_FLAGS_EN
        check("flags", 64'(o_flags), 64'(e[35:32]));
`endif
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] er, input logic [3:0] ef);
    i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1; i_ready = 1'b1;
    cycle();
    i_valid = 1'b0;
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) cycle();
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_lat"}, 64'(out_cyc - in_cyc), 64'd3);
    check({tag, "_res"}, 64'(last_res), 64'(er));
`ifdef FPU_ADDER_FLAGS_EN
    check({tag, "_flg"}, 64'(last_flags), 64'(ef));
`else
    if (ef != last_flags) ; // flags not observable in this build
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_result", 64'(o_result), 64'd0);
`ifdef FPU_ADDER_FLAGS_EN
    check("rst_flags", 64'(o_flags), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // ---- directed vectors
    run_one("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    run_one("cancel",       32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000);
    run_one("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_one("tie_odd",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    run_one("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_one("inf_minus",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_one("negz_negz",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_one("negz_sub_z",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);
    run_one("z_negz",       32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    run_one("nan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    run_one("ninf_fin",     32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    run_one("underflow",    32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
    run_one("ftz_in",       32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);

    // ---- back-pressure: five ops, consumer stalls cycles 2..6
    begin : stall_test
      int          issued, base;
      logic [31:0] oa, ob;
      logic        os;
      issued = 0;
      base = out_cnt;
      oa = rnd_op(); ob = rnd_op(); os = 1'($urandom_range(0, 1));
      for (int c = 0; c < 16; c++) begin
        i_valid = (issued < 5);
        i_a = oa; i_b = ob; i_sub = os;
        i_ready = !(c >= 2 && c <= 6);
        cycle();
        if (i_valid && snap_ready) begin
          issued++;
          oa = rnd_op(); ob = rnd_op(); os = 1'($urandom_range(0, 1));
        end
        check("stall_ready", 64'(snap_ready), 64'(!(c >= 3 && c <= 6)));
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      check("stall_count", 64'(out_cnt - base), 64'd5);
      check("stall_drain", 64'(exp_q.size()), 64'd0);
    end

    // ---- random traffic with random back-pressure
    for (int c = 0; c < 600; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_a = rnd_op();
      i_b = ($urandom_range(0, 3) == 0) ? (i_a ^ 32'($urandom_range(0, 255))) : rnd_op();
      i_sub = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) cycle();
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    // ---- reset with three ops in flight
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1;
      i_a = rnd_op(); i_b = rnd_op(); i_sub = 1'($urandom_range(0, 1));
      cycle();
    end
    i_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_result", 64'(o_result), 64'd0);
    check("midrst_ready", 64'(o_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("postrst_valid", 64'(snap_valid), 64'd0);
      check("postrst_ready", 64'(snap_ready), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
